fp_match_sched: RTL and testbench

FP_MATCH_SCHED -- requirements
Module: fp_match_sched

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fp_match_sched_if.sv | 40 ++++
 rtl/fp_key_edge.sv | 20 ++
 rtl/fp_match_sched.sv | 195 +++++++++++++++++++
 tb/tb_fp_match_sched.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the fingerprint match scheduler.
// Contents:
//   state_t         scheduler FSM states
//   mode_t          whether the active capture is an enrollment or a check
//   SLOT_*          RAM slot numbers that appear on write_sel
//   RES_*           values of result_code
//   slot_onehot()   template index -> fp_start one-hot code
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAP       = 3'd1,
    CMP_ISSUE = 3'd2,
    CMP_WAIT  = 3'd3,
    REPORT    = 3'd4
  } state_t;

  typedef enum logic {
    ENROLL = 1'b0,
    CHECK  = 1'b1
  } mode_t;

  localparam logic [1:0] SLOT_A     = 2'd0;
  localparam logic [1:0] SLOT_B     = 2'd1;
  localparam logic [1:0] SLOT_PROBE = 2'd2;

  localparam logic [1:0] RES_NO_MATCH = 2'b00;
  localparam logic [1:0] RES_MATCH    = 2'b01;
  localparam logic [1:0] RES_NO_TMPL  = 2'b10;
  localparam logic [1:0] RES_TIMEOUT  = 2'b11;

  // Template 0 is compared through fp_start[0], template 1 through fp_start[1].
  function automatic logic [1:0] slot_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fp_match_sched_if.sv
// Bundle of key, capture, comparator and result signals around the scheduler.
// Modports:
//   master  scheduler side: drives write_sel/write_en/fp_start/tmpl_valid/
//           busy/result_*, samples keys, frame_done, fp_state, fp_match
//   slave   environment side (keys, capture engine, comparator)
//
// Handshake semantics: the scheduler raises write_en and holds it until
// frame_done is seen high on a rising edge (or the timeout fires); frame_done
// is a single-cycle completion pulse. A compare is requested by a one-cycle
// fp_start pulse; the comparator acknowledges by raising fp_state while busy,
// and its verdict on fp_match is taken in the first cycle fp_state is low
// again. result_valid is a one-cycle pulse with no back-pressure; result_code
// and result_idx stay stable until the next pulse.
interface fp_match_sched_if;
  logic       update_in;
  logic       check_in;
  logic       frame_done;
  logic       fp_state;
  logic       fp_match;
  logic [1:0] write_sel;
  logic       write_en;
  logic [1:0] fp_start;
  logic [1:0] tmpl_valid;
  logic       busy;
  logic       result_valid;
  logic [1:0] result_code;
  logic       result_idx;

  modport master (
    input  update_in, check_in, frame_done, fp_state, fp_match,
    output write_sel, write_en, fp_start, tmpl_valid, busy,
           result_valid, result_code, result_idx
  );

  modport slave (
    output update_in, check_in, frame_done, fp_state, fp_match,
    input  write_sel, write_en, fp_start, tmpl_valid, busy,
           result_valid, result_code, result_idx
  );
endinterface

// File: rtl/fp_key_edge.sv
// Rising-edge detector for one debounced key level.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   level       debounced key level
//   rise        high for the one cycle where level is 1 and was 0 last cycle
module fp_key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;
endmodule

// File: rtl/fp_match_sched.sv
// Enrollment / verification scheduler for a two-template fingerprint matcher.
// An update key captures a template into slot A or B (alternating); a check
// key captures a probe image and compares it against each valid template,
// lowest index first, reporting match / no match / no template / timeout.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   bus         fp_match_sched_if.master (keys, capture, comparator, result)
//   state_dbg   current FSM state
// Parameters:
//   TIMEOUT_CYC max cycles spent in CAP or CMP_WAIT before giving up
//   TO_W        timeout counter width (TIMEOUT_CYC < 2**TO_W)
module fp_match_sched
  import fp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned TO_W        = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_match_sched_if.master bus,
  output state_t           state_dbg
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic upd_rise, chk_rise;

  fp_key_edge u_upd_edge (.clk(clk), .rst_n(rst_n), .level(bus.update_in), .rise(upd_rise));
  fp_key_edge u_chk_edge (.clk(clk), .rst_n(rst_n), .level(bus.check_in),  .rise(chk_rise));

  state_t          state, state_nxt;
  mode_t           mode, mode_nxt;
  logic            ptr, ptr_nxt;
  logic            cur, cur_nxt;
  logic            seen, seen_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic [1:0]      write_sel, write_sel_nxt;
  logic            write_en, write_en_nxt;
  logic [1:0]      tmpl_valid, tmpl_valid_nxt;
  logic            result_valid, result_valid_nxt;
  logic [1:0]      result_code, result_code_nxt;
  logic            result_idx, result_idx_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode         <= ENROLL;
      ptr          <= 1'b0;
      cur          <= 1'b0;
      seen         <= 1'b0;
      cnt          <= '0;
      write_sel    <= SLOT_A;
      write_en     <= 1'b0;
      tmpl_valid   <= 2'b00;
      result_valid <= 1'b0;
      result_code  <= RES_NO_MATCH;
      result_idx   <= 1'b0;
    end else begin
      state        <= state_nxt;
      mode         <= mode_nxt;
      ptr          <= ptr_nxt;
      cur          <= cur_nxt;
      seen         <= seen_nxt;
      cnt          <= cnt_nxt;
      write_sel    <= write_sel_nxt;
      write_en     <= write_en_nxt;
      tmpl_valid   <= tmpl_valid_nxt;
      result_valid <= result_valid_nxt;
      result_code  <= result_code_nxt;
      result_idx   <= result_idx_nxt;
    end
  end

  // result_valid is raised together with the move into REPORT, so it is high
  // exactly for the single REPORT cycle.
  always_comb begin
    state_nxt        = state;
    mode_nxt         = mode;
    ptr_nxt          = ptr;
    cur_nxt          = cur;
    seen_nxt         = seen;
    cnt_nxt          = cnt;
    write_sel_nxt    = write_sel;
    write_en_nxt     = write_en;
    tmpl_valid_nxt   = tmpl_valid;
    result_valid_nxt = 1'b0;
    result_code_nxt  = result_code;
    result_idx_nxt   = result_idx;

    case (state)
      IDLE: begin
        // Update wins over a simultaneous check; edges seen in other states
        // are simply ignored.
        if (upd_rise) begin
          write_sel_nxt = ptr ? SLOT_B : SLOT_A;
          write_en_nxt  = 1'b1;
          mode_nxt      = ENROLL;
          cnt_nxt       = '0;
          state_nxt     = CAP;
        end else if (chk_rise) begin
          if (tmpl_valid == 2'b00) begin
            result_valid_nxt = 1'b1;
            result_code_nxt  = RES_NO_TMPL;
            result_idx_nxt   = 1'b0;
            state_nxt        = REPORT;
          end else begin
            write_sel_nxt = SLOT_PROBE;
            write_en_nxt  = 1'b1;
            mode_nxt      = CHECK;
            cnt_nxt       = '0;
            state_nxt     = CAP;
          end
        end
      end

      CAP: begin
        if (bus.frame_done) begin
          write_en_nxt = 1'b0;
          if (mode == ENROLL) begin
            tmpl_valid_nxt[ptr] = 1'b1;
            ptr_nxt             = ~ptr;
            state_nxt           = IDLE;
          end else begin
            // At least one template is valid here: start from slot 0 if it
            // is present, otherwise slot 1.
            cur_nxt   = ~tmpl_valid[0];
            state_nxt = CMP_ISSUE;
          end
        end else if (cnt == TO_LAST) begin
          write_en_nxt = 1'b0;
          if (mode == ENROLL) begin
            state_nxt = IDLE;
          end else begin
            result_valid_nxt = 1'b1;
            result_code_nxt  = RES_TIMEOUT;
            result_idx_nxt   = 1'b0;
            state_nxt        = REPORT;
          end
        end else begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end

      CMP_ISSUE: begin
        cnt_nxt   = '0;
        seen_nxt  = 1'b0;
        state_nxt = CMP_WAIT;
      end

      CMP_WAIT: begin
        if (bus.fp_state) seen_nxt = 1'b1;
        // A low fp_state only counts once the comparator has been seen busy,
        // so the cycles before it picks up fp_start are not mistaken for done.
        if (!bus.fp_state && seen) begin
          if (bus.fp_match) begin
            result_valid_nxt = 1'b1;
            result_code_nxt  = RES_MATCH;
            result_idx_nxt   = cur;
            state_nxt        = REPORT;
          end else if (!cur && tmpl_valid[1]) begin
            cur_nxt   = 1'b1;
            state_nxt = CMP_ISSUE;
          end else begin
            result_valid_nxt = 1'b1;
            result_code_nxt  = RES_NO_MATCH;
            result_idx_nxt   = 1'b0;
            state_nxt        = REPORT;
          end
        end else if (cnt == TO_LAST) begin
          result_valid_nxt = 1'b1;
          result_code_nxt  = RES_TIMEOUT;
          result_idx_nxt   = 1'b0;
          state_nxt        = REPORT;
        end else begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end

      REPORT: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.write_sel    = write_sel;
  assign bus.write_en     = write_en;
  assign bus.fp_start     = (state == CMP_ISSUE) ? slot_onehot(cur) : 2'b00;
  assign bus.tmpl_valid   = tmpl_valid;
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = result_valid;
  assign bus.result_code  = result_code;
  assign bus.result_idx   = result_idx;
  assign state_dbg        = state;

endmodule

// File: tb/tb_fp_match_sched.sv
// Bench for fp_match_sched: directed scenarios plus randomized enroll/check
// traffic, checked against a slot/pointer model of the scheduler's behaviour.
module tb_fp_match_sched;
  import fp_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;

  always #5 clk = ~clk;

  fp_match_sched_if bus();

  fp_match_sched #(.TIMEOUT_CYC(TO), .TO_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int rv_count = 0;
  int we_count = 0;
  int fs_count = 0;

  logic [1:0] m_tv;     // model: enrolled templates
  logic       m_ptr;    // model: next slot to enroll
  logic [1:0] exp_q[$]; // expected fp_start pulses in order

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // All sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (bus.result_valid) rv_count++;
    if (bus.write_en) we_count++;
    if (bus.fp_start != 2'b00) fs_count++;
  endtask

  task automatic wait_for(input bit on_result, input int budget, output bit got, output int waited);
    waited = 0;
    while (!(on_result ? bus.result_valid : (bus.fp_start != 2'b00)) && waited < budget) begin
      tick();
      waited++;
    end
    got = on_result ? bus.result_valid : (bus.fp_start != 2'b00);
  endtask

  // ---------------- driver tasks ----------------
  task automatic enroll(input int fd_delay);
    int   rv0;
    logic exp_sel;
    rv0 = rv_count;
    bus.update_in = 1'b1;
    tick();
    bus.update_in = 1'b0;
    check_val("enr_we", bus.write_en, 1);
    check_val("enr_sel", bus.write_sel, {1'b0, m_ptr});
    check_val("enr_busy", bus.busy, 1);
    repeat (fd_delay - 1) tick();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    exp_sel = m_ptr;
    m_tv[m_ptr] = 1'b1;
    m_ptr = ~m_ptr;
    check_val("enr_tmpl", bus.tmpl_valid, m_tv);
    check_val("enr_we_drop", bus.write_en, 0);
    check_val("enr_sel_hold", bus.write_sel, {1'b0, exp_sel});
    check_val("enr_idle", bus.busy, 0);
    check_val("enr_no_result", rv_count - rv0, 0);
  endtask

  task automatic run_check(input int fd_delay, input logic [1:0] verdict, input int busy_cyc);
    int         rv0, we0, waited;
    bit         got;
    logic [1:0] exp_code, exp_start;
    logic       exp_idx;
    rv0 = rv_count;
    we0 = we_count;
    exp_q.delete();
    exp_code = RES_NO_TMPL;
    exp_idx  = 1'b0;
    if (m_tv != 2'b00) begin
      exp_code = RES_NO_MATCH;
      for (int i = 0; i < 2; i++) begin
        if (m_tv[i] && exp_code != RES_MATCH) begin
          exp_q.push_back(i == 0 ? 2'b01 : 2'b10);
          if (verdict[i]) begin
            exp_code = RES_MATCH;
            exp_idx  = (i == 1);
          end
        end
      end
    end

    bus.check_in = 1'b1;
    tick();
    bus.check_in = 1'b0;
    if (m_tv == 2'b00) begin
      wait_for(1'b1, 2, got, waited);
      check_val("nt_result_seen", got, 1);
    end else begin
      check_val("chk_we", bus.write_en, 1);
      check_val("chk_sel", bus.write_sel, SLOT_PROBE);
      repeat (fd_delay - 1) tick();
      bus.frame_done = 1'b1;
      tick();
      bus.frame_done = 1'b0;
      check_val("chk_we_drop", bus.write_en, 0);
      while (exp_q.size() > 0) begin
        exp_start = exp_q.pop_front();
        wait_for(1'b0, 10, got, waited);
        check_val("start_seen", got, 1);
        check_val("fp_start", bus.fp_start, exp_start);
        tick();
        check_val("start_one_cycle", bus.fp_start, 0);
        bus.fp_state = 1'b1;
        repeat (busy_cyc) tick();
        bus.fp_state = 1'b0;
        bus.fp_match = (exp_start == 2'b01) ? verdict[0] : verdict[1];
        tick();
        bus.fp_match = 1'b0;
      end
      wait_for(1'b1, 0, got, waited);
      check_val("result_seen", got, 1);
    end
    check_val("result_code", bus.result_code, exp_code);
    if (exp_code == RES_MATCH) check_val("result_idx", bus.result_idx, exp_idx);
    if (m_tv == 2'b00) check_val("nt_no_capture", we_count - we0, 0);
    tick();
    check_val("result_pulse", bus.result_valid, 0);
    check_val("result_hold", bus.result_code, exp_code);
    check_val("result_idle", bus.busy, 0);
    check_val("result_count", rv_count - rv0, 1);
  endtask

  // Update and check keys together, then a check edge during capture.
  task automatic both_keys();
    int rv0;
    rv0 = rv_count;
    bus.update_in = 1'b1;
    bus.check_in  = 1'b1;
    tick();
    bus.update_in = 1'b0;
    bus.check_in  = 1'b0;
    check_val("both_we", bus.write_en, 1);
    check_val("both_sel", bus.write_sel, {1'b0, m_ptr});
    tick();
    bus.check_in = 1'b1;
    tick();
    bus.check_in = 1'b0;
    tick();
    check_val("cap_chk_sel", bus.write_sel, {1'b0, m_ptr});
    check_val("cap_chk_busy", bus.busy, 1);
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    m_tv[m_ptr] = 1'b1;
    m_ptr = ~m_ptr;
    check_val("both_tmpl", bus.tmpl_valid, m_tv);
    repeat (4) tick();
    check_val("both_idle", bus.busy, 0);
    check_val("both_no_result", rv_count - rv0, 0);
  endtask

  // Comparator never goes busy: timeout must fire 16 cycles into CMP_WAIT.
  task automatic timeout_cmp();
    int fs0, rv0, waited;
    bit got;
    fs0 = fs_count;
    rv0 = rv_count;
    bus.check_in = 1'b1;
    tick();
    bus.check_in = 1'b0;
    repeat (2) tick();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    wait_for(1'b0, 5, got, waited);
    check_val("to_start_seen", got, 1);
    check_val("to_start", bus.fp_start, m_tv[0] ? 2'b01 : 2'b10);
    wait_for(1'b1, 40, got, waited);
    check_val("to_result_seen", got, 1);
    check_val("to_latency", waited, TO + 1);
    check_val("to_code", bus.result_code, RES_TIMEOUT);
    check_val("to_start_count", fs_count - fs0, 1);
    check_val("to_result_count", rv_count - rv0, 1);
    tick();
  endtask

  // Capture never completes.
  task automatic cap_timeout(input bit is_check);
    int rv0, waited;
    bit got;
    rv0 = rv_count;
    if (is_check) bus.check_in = 1'b1;
    else          bus.update_in = 1'b1;
    tick();
    bus.check_in  = 1'b0;
    bus.update_in = 1'b0;
    if (is_check) begin
      wait_for(1'b1, 40, got, waited);
      check_val("capto_seen", got, 1);
      check_val("capto_latency", waited, TO);
      check_val("capto_code", bus.result_code, RES_TIMEOUT);
      check_val("capto_we", bus.write_en, 0);
      tick();
    end else begin
      repeat (TO + 4) tick();
      check_val("enrto_idle", bus.busy, 0);
      check_val("enrto_we", bus.write_en, 0);
      check_val("enrto_tmpl", bus.tmpl_valid, m_tv);
      check_val("enrto_no_result", rv_count - rv0, 0);
    end
  endtask

  task automatic reset_mid_compare();
    int rv0, waited;
    bit got;
    bus.check_in = 1'b1;
    tick();
    bus.check_in = 1'b0;
    tick();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    wait_for(1'b0, 5, got, waited);
    check_val("rstm_start_seen", got, 1);
    tick();
    bus.fp_state = 1'b1;
    tick();
    check_val("rstm_in_wait", state_dbg, CMP_WAIT);
    rv0 = rv_count;
    rst_n = 1'b0;
    tick();
    check_val("rstm_state", state_dbg, IDLE);
    check_val("rstm_sel", bus.write_sel, 0);
    check_val("rstm_we", bus.write_en, 0);
    check_val("rstm_start", bus.fp_start, 0);
    check_val("rstm_tmpl", bus.tmpl_valid, 0);
    check_val("rstm_busy", bus.busy, 0);
    check_val("rstm_rv", bus.result_valid, 0);
    check_val("rstm_code", bus.result_code, 0);
    check_val("rstm_idx", bus.result_idx, 0);
    rst_n = 1'b1;
    bus.fp_state = 1'b0;
    m_tv  = 2'b00;
    m_ptr = 1'b0;
    repeat (2) tick();
    check_val("rstm_no_result", rv_count - rv0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.update_in  = 1'b0;
    bus.check_in   = 1'b0;
    bus.frame_done = 1'b0;
    bus.fp_state   = 1'b0;
    bus.fp_match   = 1'b0;
    m_tv  = 2'b00;
    m_ptr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_val("rst_state", state_dbg, IDLE);
    check_val("rst_sel", bus.write_sel, 0);
    check_val("rst_we", bus.write_en, 0);
    check_val("rst_start", bus.fp_start, 0);
    check_val("rst_tmpl", bus.tmpl_valid, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_rv", bus.result_valid, 0);
    check_val("rst_code", bus.result_code, 0);
    check_val("rst_idx", bus.result_idx, 0);

    run_check(3, 2'b00, 1);      // no templates
    enroll(5);                   // slot A
    enroll(5);                   // slot B
    enroll(5);                   // slot A again
    run_check(4, 2'b10, 3);      // A misses, B matches
    both_keys();
    timeout_cmp();
    cap_timeout(1'b1);
    cap_timeout(1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) enroll(int'($urandom_range(1, 6)));
      else run_check(int'($urandom_range(1, 6)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 2)) tick();
    end

    reset_mid_compare();
    run_check(2, 2'b11, 1);      // templates are gone after reset
    enroll(2);                   // pointer restarts at slot A

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
